lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store control stage directly upstream of the byte-lane data memory (dmem).
- Accepts one load or store request at a time from the execute stage.
- Aligned accesses go out as one memory beat with the correct lane enables. Misaligned accesses are split into byte-serial beats.
- Load bytes are reassembled and sign/zero-extended internally; out-of-range or invalid requests return a fault.

Parameters:
DEPTH_WORDS, 32, number of 32-bit words in dmem; valid byte addresses are 0 .. 4*DEPTH_WORDS-1
AW, 5, width of mem_daddr word index (log2 DEPTH_WORDS)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  stage can accept a request
req_store  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 invalid
req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and faults
resp_fault  out  1  request rejected, no memory access made
mem_daddr  out  AW  word index to dmem
mem_dmemin  out  32  write data to dmem, right-justified
mem_wemen  out  4  write lane enables (legal values: 0,1,2,4,8,3,12,15)
mem_re  out  4  read lane enables (same legal set)
mem_signcontrol  out  1  held at 1 (unsigned); extension is done in this block
mem_new  out  1  toggles on every read beat to retrigger dmem read
mem_dmemout  in  32  dmem read data, right-justified

Behaviour:
- Reset: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_wemen=0, mem_re=0, mem_daddr=0, mem_dmemin=0, mem_new=0, beat counter=0, assembly register=0.
- Accept: req_valid & req_ready at a rising edge latches all req_* fields. req_ready=1 only in IDLE. Requests presented while busy are ignored and must be held by the source.
- Fault check at accept:
  - size=11 is a fault.
  - A span where addr + nbytes - 1 > 4*DEPTH_WORDS-1 is a fault.
  - On fault, go to RESP directly: resp_fault=1, no wemen/re asserted at any point.
- Aligned: byte (any offset o), half (o=0 or 2), word (o=0).
  - One beat. mem_daddr = addr[AW+1:2].
  - Lanes: byte 1<<o; half 3 (o=0) or 12 (o=2); word 15.
- Misaligned: half with o=1 or 3; word with o≠0.
  - nbytes byte beats, k=0..nbytes-1.
  - Byte address a_k = addr+k; daddr = a_k[AW+1:2]; lane = 1<<a_k[1:0].
  - Word wrap to the next index is handled naturally by a_k.
- FSM states:
  - IDLE: on accept, go to ACCESS, or to RESP on fault.
  - ACCESS: one cycle per beat; mem_* driven from registered state only. A store commits at the edge ending the beat. A load captures mem_dmemout at that edge. After the last beat, go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_* fields return to 0 in IDLE.
- Store data:
  - Aligned: mem_dmemin = req_wdata right-justified (low 8/16/32 bits significant).
  - Byte beat k: mem_dmemin[7:0] = wdata[8k+7:8k], upper bits 0.
- Load assembly:
  - Aligned: take the low nbytes of mem_dmemout.
  - Byte beat k: mem_dmemout[7:0] goes to assembly[8k+7:8k] (little-endian).
  - Extension is applied when entering RESP, per req_size and req_unsigned.
- Latency, counted from the accept edge:
  - Aligned: resp_valid in cycle 2.
  - Misaligned: resp_valid in cycle nbytes+1.
  - Fault: resp_valid in cycle 1.
- Outside ACCESS: mem_wemen=0 and mem_re=0; loads never assert wemen; stores never assert re.
- Reset mid-operation: immediate return to IDLE with reset values. Bytes of a split store already committed stay committed; there is no rollback.

Decomposition:
- Shared package lsu_pkg: size encodings, FSM state encodings, and the lane-enable constants (LANE_B0..B3, LANE_HLO=3, LANE_HHI=12, LANE_W=15).
- One sub-module, lsu_extend: combinational sign/zero extension from size and unsigned flag.

Test Plan:
- Word load at 0x00 on initial memory -> resp_rdata=0x33221100 at cycle 2 after accept; fault=0; one beat with re=15 and daddr=0.
- Byte load at 0x08: signed -> 0xFFFFFF88; unsigned -> 0x00000088; re=1 on daddr=2.
- Half load at 0x03, signed -> two beats (daddr=0 re=8, then daddr=1 re=1); resp_rdata=0x00004433 at cycle 3.
- Word store 0x11223344 at 0x0E, then aligned loads of 0x0C and 0x10 -> 0x3344DDCC and 0x00001122; four beats with wemen 4,8,1,2.
- Word load at 0x7E, and separately size=11 at 0x00 -> resp_fault=1 at cycle 1; wemen and re stay 0 throughout.
- Misaligned word store at 0x01 with rst_n pulled low after beat 2 -> outputs return to reset values immediately; later load shows only bytes at 0x01 and 0x02 written; req_ready=1 after reset release.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store control stage.
// Access sizes, FSM states, dmem lane-enable constants and size helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    localparam logic [3:0] LANE_B0  = 4'b0001;
    localparam logic [3:0] LANE_B1  = 4'b0010;
    localparam logic [3:0] LANE_B2  = 4'b0100;
    localparam logic [3:0] LANE_B3  = 4'b1000;
    localparam logic [3:0] LANE_HLO = 4'b0011;
    localparam logic [3:0] LANE_HHI = 4'b1100;
    localparam logic [3:0] LANE_W   = 4'b1111;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    size_bytes = 3'd1;
            SZ_H:    size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    size_mask = 32'h0000_00FF;
            SZ_H:    size_mask = 32'h0000_FFFF;
            default: size_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// lsu_extend: combinational sign/zero extension of assembled load data.
// Ports: size (access size), uns (1=zero-extend), din (raw), dout (extended).
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] din,
    output logic [31:0] dout
);

    always_comb begin
        dout = din;
        case (size)
            SZ_B: dout = uns ? {24'd0, din[7:0]}
                             : {{24{din[7]}}, din[7:0]};
            SZ_H: dout = uns ? {16'd0, din[15:0]}
                             : {{16{din[15]}}, din[15:0]};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control stage in front of the byte-lane dmem.
// Ports: req_* request handshake from execute, resp_* completion pulse,
// mem_* dmem interface (word index, lane enables, right-justified data).
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 32,
    parameter int AW          = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_store,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_fault,
    output logic [AW-1:0] mem_daddr,
    output logic [31:0]   mem_dmemin,
    output logic [3:0]    mem_wemen,
    output logic [3:0]    mem_re,
    output logic          mem_signcontrol,
    output logic          mem_new,
    input  logic [31:0]   mem_dmemout
);

    localparam logic [32:0] MAX_BYTE = 33'(4 * DEPTH_WORDS - 1);

    state_e        state, state_nx;
    logic          store_q, uns_q, misal_q, fault_q, new_q;
    logic [1:0]    size_q, beat;
    logic [AW+1:0] addr_q, a_k;
    logic [31:0]   wdata_q, asm_q, asm_nx, rdata_q, ext;
    logic [31:0]   mask_q, st_data;
    logic [3:0]    lane;
    logic [2:0]    req_nb, nb_q;
    logic [32:0]   span_end;
    logic          accept, req_fault, req_misal, last_beat;

    assign accept    = req_valid & req_ready;
    assign req_nb    = size_bytes(req_size);
    assign span_end  = {1'b0, req_addr} + {30'd0, req_nb} - 33'd1;
    assign req_fault = (req_size == SZ_X) || (span_end > MAX_BYTE);
    assign req_misal = ((req_size == SZ_H) && req_addr[0])
                    || ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));

    assign nb_q      = size_bytes(size_q);
    assign mask_q    = size_mask(size_q);
    assign last_beat = !misal_q || ({1'b0, beat} == nb_q - 3'd1);
    // Aligned accesses run a single beat at k=0, so a_k covers both cases.
    assign a_k       = addr_q + {{AW{1'b0}}, beat};

    always_comb begin
        lane = LANE_W;
        if (misal_q) begin
            lane = LANE_B0 << a_k[1:0];
        end else begin
            case (size_q)
                SZ_B:    lane = LANE_B0 << addr_q[1:0];
                SZ_H:    lane = addr_q[1] ? LANE_HHI : LANE_HLO;
                default: lane = LANE_W;
            endcase
        end
    end

    assign st_data = misal_q ? {24'd0, wdata_q[{beat, 3'b000} +: 8]}
                             : (wdata_q & mask_q);

    always_comb begin
        asm_nx = asm_q;
        if (state == S_ACCESS && !store_q) begin
            if (misal_q) asm_nx[{beat, 3'b000} +: 8] = mem_dmemout[7:0];
            else         asm_nx = mem_dmemout & mask_q;
        end
    end

    lsu_extend u_ext (
        .size (size_q),
        .uns  (uns_q),
        .din  (asm_nx),
        .dout (ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        mem_daddr  = '0;
        mem_dmemin = '0;
        mem_wemen  = '0;
        mem_re     = '0;
        unique case (state)
            S_IDLE: begin
                if (accept) state_nx = req_fault ? S_RESP : S_ACCESS;
            end
            S_ACCESS: begin
                mem_daddr = a_k[AW+1:2];
                if (store_q) begin
                    mem_wemen  = lane;
                    mem_dmemin = st_data;
                end else begin
                    mem_re = lane;
                end
                if (last_beat) state_nx = S_RESP;
            end
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            misal_q <= 1'b0;
            beat    <= 2'd0;
            asm_q   <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            new_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        store_q <= req_store;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr[AW+1:0];
                        wdata_q <= req_wdata;
                        misal_q <= req_misal;
                        beat    <= 2'd0;
                        asm_q   <= '0;
                        rdata_q <= '0;
                        fault_q <= req_fault;
                        // first read beat starts next cycle
                        if (!req_fault && !req_store) new_q <= ~new_q;
                    end
                end
                S_ACCESS: begin
                    asm_q <= asm_nx;
                    if (last_beat) begin
                        rdata_q <= store_q ? 32'd0 : ext;
                        fault_q <= 1'b0;
                    end else begin
                        beat <= beat + 2'd1;
                        if (!store_q) new_q <= ~new_q;
                    end
                end
                default: begin
                    rdata_q <= '0;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready       = (state == S_IDLE);
    assign resp_valid      = (state == S_RESP);
    assign resp_rdata      = rdata_q;
    assign resp_fault      = fault_q;
    assign mem_new         = new_q;
    assign mem_signcontrol = 1'b1;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed plus randomized checks of lsu_ctrl against a
// byte-array reference model and a byte-lane dmem model.
module tb_lsu_ctrl;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int MAXB = 4 * DW - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_store = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [31:0]   req_addr = 32'd0;
    logic [31:0]   req_wdata = 32'd0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_fault;
    logic [AW-1:0] mem_daddr;
    logic [31:0]   mem_dmemin;
    logic [3:0]    mem_wemen;
    logic [3:0]    mem_re;
    logic          mem_signcontrol;
    logic          mem_new;
    logic [31:0]   mem_dmemout;

    int checks = 0;
    int failures = 0;
    logic new_par = 1'b0;

    logic [7:0] dm [0:MAXB];
    logic [7:0] rm [0:MAXB];

    always #5 clk = ~clk;

    lsu_ctrl #(.DEPTH_WORDS(DW), .AW(AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_store       (req_store),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_fault      (resp_fault),
        .mem_daddr       (mem_daddr),
        .mem_dmemin      (mem_dmemin),
        .mem_wemen       (mem_wemen),
        .mem_re          (mem_re),
        .mem_signcontrol (mem_signcontrol),
        .mem_new         (mem_new),
        .mem_dmemout     (mem_dmemout)
    );

    function automatic logic [31:0] rd(input logic [AW-1:0] wa,
                                       input logic [3:0] re);
        int idx;
        rd = 32'd0;
        idx = 0;
        for (int j = 0; j < 4; j++) begin
            if (re[j]) begin
                rd[8*idx +: 8] = dm[4*wa + j];
                idx++;
            end
        end
    endfunction

    assign mem_dmemout = rd(mem_daddr, mem_re);

    always @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            if (mem_wemen[j])
                dm[4*mem_daddr + j] <=
                    mem_dmemin[8*$countones(mem_wemen & 4'((1 << j) - 1)) +: 8];
        end
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                       input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic legal(input logic [3:0] l);
        legal = (l == 4'd0) || (l == 4'd1) || (l == 4'd2) || (l == 4'd4)
             || (l == 4'd8) || (l == 4'd3) || (l == 4'd12) || (l == 4'd15);
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            chk({31'd0, legal(mem_wemen)}, 32'd1, "wemen_legal");
            chk({31'd0, legal(mem_re)}, 32'd1, "re_legal");
            chk({31'd0, (mem_wemen != 0) && (mem_re != 0)}, 32'd0,
                "wemen_re_both");
        end
    end

    task automatic chk_reset(input string p);
        chk({31'd0, req_ready}, 32'd1, {p, "_ready"});
        chk({31'd0, resp_valid}, 32'd0, {p, "_resp_valid"});
        chk(resp_rdata, 32'd0, {p, "_resp_rdata"});
        chk({31'd0, resp_fault}, 32'd0, {p, "_resp_fault"});
        chk({28'd0, mem_wemen}, 32'd0, {p, "_wemen"});
        chk({28'd0, mem_re}, 32'd0, {p, "_re"});
        chk({27'd0, mem_daddr}, 32'd0, {p, "_daddr"});
        chk(mem_dmemin, 32'd0, {p, "_dmemin"});
        chk({31'd0, mem_new}, 32'd0, {p, "_mem_new"});
    endtask

    task automatic txn(input logic st, input logic [1:0] sz,
                       input logic un, input logic [31:0] ad,
                       input logic [31:0] wd, output logic [31:0] got);
        int nb, lat, c;
        logic flt, alig, done;
        logic [31:0] exp_d;
        longint v;
        logic [9:0] eb[$];
        logic [9:0] ob[$];
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        flt = (sz == 2'd3) || (longint'(ad) + nb - 1 > longint'(MAXB));
        alig = (ad % nb) == 0;
        exp_d = 32'd0;
        if (!flt) begin
            if (alig)
                eb.push_back({5'(ad >> 2), 4'(((1 << nb) - 1) << (ad % 4)), st});
            else
                for (int k = 0; k < nb; k++)
                    eb.push_back({5'((ad + k) >> 2), 4'(1 << ((ad + k) % 4)), st});
            if (st) begin
                for (int i = 0; i < nb; i++) rm[ad + i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < nb; i++)
                    v = v | (longint'(rm[ad + i]) << (8 * i));
                if (!un && v[8*nb-1]) v = v - (longint'(1) << (8 * nb));
                exp_d = v[31:0];
                if (eb.size() % 2 == 1) new_par = ~new_par;
            end
        end
        lat = flt ? 1 : (alig ? 2 : nb + 1);

        @(negedge clk);
        req_store = st; req_size = sz; req_unsigned = un;
        req_addr = ad; req_wdata = wd; req_valid = 1'b1;
        chk({31'd0, req_ready}, 32'd1, "accept_ready");
        @(posedge clk);
        #1 req_valid = 1'b0;

        c = 0;
        done = 1'b0;
        while (!done && c < 12) begin
            @(negedge clk);
            c++;
            if (resp_valid) begin
                done = 1'b1;
            end else begin
                if (mem_wemen != 0 || mem_re != 0)
                    ob.push_back({mem_daddr, mem_wemen | mem_re, mem_wemen != 0});
                if (c == 1) chk({31'd0, req_ready}, 32'd0, "busy_ready");
            end
        end
        got = resp_rdata;
        chk({31'd0, done}, 32'd1, "resp_timeout");
        chk(c, lat, "latency");
        chk({31'd0, resp_fault}, {31'd0, flt}, "resp_fault");
        chk(resp_rdata, exp_d, "resp_rdata");
        chk({28'd0, mem_wemen | mem_re}, 32'd0, "lanes_in_resp");
        chk({31'd0, mem_new}, {31'd0, new_par}, "mem_new");
        chk(ob.size(), eb.size(), "beat_count");
        for (int i = 0; i < eb.size() && i < ob.size(); i++)
            chk({22'd0, ob[i]}, {22'd0, eb[i]}, $sformatf("beat%0d", i));

        @(negedge clk);
        chk({31'd0, resp_valid}, 32'd0, "idle_resp_valid");
        chk(resp_rdata, 32'd0, "idle_rdata");
        chk({31'd0, resp_fault}, 32'd0, "idle_fault");
        chk({31'd0, req_ready}, 32'd1, "idle_ready");
    endtask

    logic [31:0] got;

    initial begin
        for (int i = 0; i <= MAXB; i++) begin
            dm[i] = (i < 16) ? 8'(i * 17) : 8'd0;
            rm[i] = dm[i];
        end
        #3;
        chk_reset("reset");
        chk({31'd0, mem_signcontrol}, 32'd1, "signcontrol");
        @(negedge clk);
        rst_n = 1'b1;

        txn(1'b0, 2'd2, 1'b0, 32'h00, 32'd0, got);
        chk(got, 32'h33221100, "plan_word_ld0");
        txn(1'b0, 2'd0, 1'b0, 32'h08, 32'd0, got);
        chk(got, 32'hFFFFFF88, "plan_byte_s");
        txn(1'b0, 2'd0, 1'b1, 32'h08, 32'd0, got);
        chk(got, 32'h00000088, "plan_byte_u");
        txn(1'b0, 2'd1, 1'b0, 32'h03, 32'd0, got);
        chk(got, 32'h00004433, "plan_half_mis");
        txn(1'b1, 2'd2, 1'b0, 32'h0E, 32'h11223344, got);
        txn(1'b0, 2'd2, 1'b0, 32'h0C, 32'd0, got);
        chk(got, 32'h3344DDCC, "plan_ld_0c");
        txn(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, got);
        chk(got, 32'h00001122, "plan_ld_10");
        txn(1'b0, 2'd2, 1'b0, 32'h7E, 32'd0, got);
        txn(1'b0, 2'd3, 1'b0, 32'h00, 32'd0, got);
        txn(1'b1, 2'd1, 1'b0, 32'h7F, 32'h0000BEEF, got);
        txn(1'b1, 2'd2, 1'b0, 32'h7C, 32'hCAFEF00D, got);
        txn(1'b0, 2'd1, 1'b0, 32'h7E, 32'd0, got);
        chk(got, 32'hFFFFCAFE, "top_half");

        @(negedge clk);
        req_store = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h01; req_wdata = 32'hA5B6C7D8; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk({28'd0, mem_wemen}, 32'd2, "rst_beat0_we");
        chk(mem_dmemin, 32'h000000D8, "rst_beat0_data");
        @(negedge clk);
        chk({28'd0, mem_wemen}, 32'd4, "rst_beat1_we");
        chk(mem_dmemin, 32'h000000C7, "rst_beat1_data");
        @(posedge clk);
        #1 rst_n = 1'b0;
        rm[1] = 8'hD8;
        rm[2] = 8'hC7;
        new_par = 1'b0;
        #1 chk_reset("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, 2'd2, 1'b0, 32'h00, 32'd0, got);
        chk(got, 32'h33C7D800, "after_rst_ld");
        txn(1'b0, 2'd2, 1'b0, 32'h04, 32'd0, got);

        for (int n = 0; n < 60; n++) begin
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 32'($urandom_range(0, 130)),
                $urandom, got);
        end

        @(negedge clk);
        for (int i = 0; i <= MAXB; i++)
            chk({24'd0, dm[i]}, {24'd0, rm[i]}, $sformatf("mem_byte%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
